// File: rtl/return_address_stack.sv
// Return address stack for fetch-stage return prediction. It can roll back speculative push/pop
// state from checkpoints. The checkpoint FIFO and rollback exist only when RAS_SNAPSHOT_EN is defined.
module return_address_stack #(
   parameter int RAS_DEPTH      = 8,
   parameter int SNAPSHOT_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        push,
   input  logic        pop,
   input  logic [31:0] new_addr,
   output logic [31:0] addr,
   output logic        valid,
   input  logic        branch_fetched,
   input  logic        branch_retired,
   input  logic        early_branch_flush,
   output logic        snapshot_overflow
);

   localparam int IW = $clog2(RAS_DEPTH);
   localparam int CW = $clog2(RAS_DEPTH + 1);
   localparam logic [CW-1:0] COUNT_MAX = CW'(RAS_DEPTH);

   logic [31:0]   stack [RAS_DEPTH];
   logic [IW-1:0] read_index, next_index, write_index, restore_index;
   logic [CW-1:0] count, next_count, restore_count;
   logic          write_en, flush_take, restore_valid;

   // Post-update pointer state. It is also the value a same-cycle checkpoint captures.
   always_comb begin
      next_index  = read_index;
      next_count  = count;
      write_en    = 1'b0;
      write_index = read_index;
      if (push && pop && count != '0) begin
         write_en = 1'b1;
      end else if (push) begin
         write_en    = 1'b1;
         write_index = read_index + IW'(1);
         next_index  = read_index + IW'(1);
         if (count != COUNT_MAX)
            next_count = count + CW'(1);
      end else if (pop && count != '0) begin
         next_index = read_index - IW'(1);
         next_count = count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (write_en && !flush_take)
         stack[write_index] <= new_addr;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         read_index <= '0;
         count      <= '0;
      end else if (flush_take) begin
         if (restore_valid) begin
            read_index <= restore_index;
            count      <= restore_count;
         end
      end else begin
         read_index <= next_index;
         count      <= next_count;
      end
   end

   assign addr  = (count != '0) ? stack[read_index] : 32'h0;
   assign valid = (count != '0);

`ifdef RAS_SNAPSHOT_EN
   localparam int SW = $clog2(SNAPSHOT_DEPTH);
   localparam int OW = $clog2(SNAPSHOT_DEPTH + 1);
   localparam logic [OW-1:0] SNAP_FULL = OW'(SNAPSHOT_DEPTH);

   logic [IW-1:0] snap_index [SNAPSHOT_DEPTH];
   logic [CW-1:0] snap_count [SNAPSHOT_DEPTH];
   logic [SW-1:0] head, tail;
   logic [OW-1:0] occupancy;
   logic          retire_take, fifo_full, overflow_q;

   assign flush_take    = early_branch_flush;
   assign restore_valid = (occupancy != '0);
   assign restore_index = snap_index[head];
   assign restore_count = snap_count[head];
   assign retire_take   = branch_retired && (occupancy != '0);
   assign fifo_full     = (occupancy == SNAP_FULL);

   always_ff @(posedge clk) begin
      if (branch_fetched && !early_branch_flush) begin
         snap_index[tail] <= next_index;
         snap_count[tail] <= next_count;
      end
   end

   // When the FIFO is full and nothing retires, head == tail.
   // The new checkpoint therefore lands on the oldest slot, and advancing head drops that slot.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head       <= '0;
         tail       <= '0;
         occupancy  <= '0;
         overflow_q <= 1'b0;
      end else if (early_branch_flush) begin
         head      <= '0;
         tail      <= '0;
         occupancy <= '0;
      end else begin
         if (branch_fetched)
            tail <= tail + SW'(1);
         if (retire_take || (branch_fetched && fifo_full))
            head <= head + SW'(1);
         if (branch_fetched && fifo_full && !retire_take)
            overflow_q <= 1'b1;
         if (branch_fetched && !retire_take && !fifo_full)
            occupancy <= occupancy + OW'(1);
         else if (!branch_fetched && retire_take)
            occupancy <= occupancy - OW'(1);
      end
   end

   assign snapshot_overflow = overflow_q;
`else
   logic unused_snapshot_inputs;

   assign flush_take             = 1'b0;
   assign restore_valid          = 1'b0;
   assign restore_index          = '0;
   assign restore_count          = '0;
   assign snapshot_overflow      = 1'b0;
   assign unused_snapshot_inputs = ^{branch_fetched, branch_retired, early_branch_flush};
`endif

endmodule

// File: tb/tb_return_address_stack.sv
// Self-checking bench for return_address_stack. It uses directed steps plus random traffic,
// checked against a queue-based model. The model follows RAS_SNAPSHOT_EN exactly as the DUT does.
module tb_return_address_stack;

   localparam int D  = 8;
   localparam int SD = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        push, pop, branch_fetched, branch_retired, early_branch_flush;
   logic [31:0] new_addr;
   logic [31:0] addr;
   logic        valid, snapshot_overflow;

   int n_compared   = 0;
   int n_mismatched = 0;

   always #5 clk = ~clk;

   return_address_stack #(.RAS_DEPTH(D), .SNAPSHOT_DEPTH(SD)) dut (
      .clk(clk), .rst(rst), .push(push), .pop(pop), .new_addr(new_addr),
      .addr(addr), .valid(valid), .branch_fetched(branch_fetched),
      .branch_retired(branch_retired), .early_branch_flush(early_branch_flush),
      .snapshot_overflow(snapshot_overflow)
   );

   // The model keeps the stack as a circular array of slots, a top slot and a depth.
   // Checkpoints are held in a plain queue.
   typedef struct {int top; int depth;} ckpt_t;
   logic [31:0] m_mem [D];
   int          m_top, m_depth;
   ckpt_t       m_ck[$];
   bit          m_ovf;

   function automatic void modelReset();
      m_top = 0; m_depth = 0; m_ck.delete(); m_ovf = 0;
   endfunction

   function automatic void modelStep(bit p, bit q, logic [31:0] a, bit bf, bit br, bit fl);
      ckpt_t c;
`ifdef RAS_SNAPSHOT_EN
      if (fl) begin
         if (m_ck.size() > 0) begin
            m_top = m_ck[0].top; m_depth = m_ck[0].depth; m_ck.delete();
         end
         return;
      end
`endif
      if (p && q && m_depth > 0) m_mem[m_top] = a;
      else if (p) begin
         m_top = (m_top + 1) % D; m_mem[m_top] = a;
         m_depth = (m_depth + 1 > D) ? D : m_depth + 1;
      end else if (q && m_depth > 0) begin
         m_top = (m_top + D - 1) % D; m_depth--;
      end
`ifdef RAS_SNAPSHOT_EN
      if (br && m_ck.size() > 0) void'(m_ck.pop_front());
      if (bf) begin
         if (m_ck.size() == SD) begin void'(m_ck.pop_front()); m_ovf = 1; end
         c.top = m_top; c.depth = m_depth;
         m_ck.push_back(c);
      end
`endif
   endfunction

   task automatic checkValue(string tag, logic [31:0] obs, logic [31:0] exp);
      n_compared++;
      assert (obs === exp) else begin
         n_mismatched++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput(string tag);
      checkValue({tag, " addr"}, addr, (m_depth > 0) ? m_mem[m_top] : 32'h0);
      checkValue({tag, " valid"}, {31'h0, valid}, {31'h0, m_depth > 0});
      checkValue({tag, " overflow"}, {31'h0, snapshot_overflow}, {31'h0, m_ovf});
   endtask

   task automatic applyStimulus(bit p, bit q, logic [31:0] a, bit bf, bit br, bit fl);
      push = p; pop = q; new_addr = a;
      branch_fetched = bf; branch_retired = br; early_branch_flush = fl;
      @(posedge clk);
      modelStep(p, q, a, bf, br, fl);
      @(negedge clk);
      push = 0; pop = 0; branch_fetched = 0; branch_retired = 0; early_branch_flush = 0;
   endtask

   initial begin
      for (int i = 0; i < D; i++) m_mem[i] = 32'h0;
      rst = 1'b0; push = 0; pop = 0; new_addr = 0;
      branch_fetched = 0; branch_retired = 0; early_branch_flush = 0;
      modelReset();
      repeat (2) @(negedge clk);
      checkOutput("reset");
      rst = 1'b1;

      // Basic push and pop
      applyStimulus(1, 0, 32'h100, 0, 0, 0);
      applyStimulus(1, 0, 32'h200, 0, 0, 0);
      checkValue("push2 addr", addr, 32'h200);
      checkOutput("push2");
      applyStimulus(0, 1, 0, 0, 0, 0);
      checkValue("pop1 addr", addr, 32'h100);
      applyStimulus(0, 1, 0, 0, 0, 0);
      checkValue("pop2 valid", {31'h0, valid}, 32'h0);
      checkValue("pop2 addr", addr, 32'h0);
      applyStimulus(0, 1, 0, 0, 0, 0);
      checkOutput("pop empty");

      // Overflow of the stack itself
      for (int i = 1; i <= 9; i++) applyStimulus(1, 0, 32'h10 * i, 0, 0, 0);
      checkValue("ovf top", addr, 32'h90);
      for (int k = 1; k <= 8; k++) begin
         applyStimulus(0, 1, 0, 0, 0, 0);
         if (k < 8) checkValue("ovf pop addr", addr, 32'h90 - 32'h10 * k);
         else checkValue("ovf drained valid", {31'h0, valid}, 32'h0);
      end

      // Simultaneous push and pop
      applyStimulus(1, 0, 32'h40, 0, 0, 0);
      applyStimulus(1, 1, 32'h44, 0, 0, 0);
      checkValue("pushpop addr", addr, 32'h44);
      applyStimulus(0, 1, 0, 0, 0, 0);
      checkValue("pushpop drain valid", {31'h0, valid}, 32'h0);

      // Rollback
      applyStimulus(1, 0, 32'h100, 1, 0, 0);
      applyStimulus(1, 0, 32'h200, 0, 0, 0);
      applyStimulus(1, 0, 32'h300, 0, 0, 1);
`ifdef RAS_SNAPSHOT_EN
      checkValue("rollback addr", addr, 32'h100);
`else
      checkValue("no rollback addr", addr, 32'h300);
`endif
      checkOutput("rollback");
      applyStimulus(0, 0, 0, 0, 0, 1);
      checkOutput("flush empty fifo");

      // Retire ordering
      applyStimulus(1, 0, 32'h500, 1, 0, 0);
      applyStimulus(1, 0, 32'h600, 1, 0, 0);
      applyStimulus(0, 1, 0, 1, 0, 0);
      applyStimulus(1, 0, 32'h700, 0, 1, 0);
      applyStimulus(0, 0, 0, 0, 1, 0);
      applyStimulus(1, 0, 32'h800, 0, 0, 1);
      checkOutput("retire order");
      applyStimulus(0, 0, 0, 0, 1, 0);
      checkOutput("retire empty");

      // Checkpoint FIFO overflow
      for (int i = 0; i < 9; i++) applyStimulus(1, 0, 32'hA00 + i, 1, 0, 0);
      checkOutput("snap ovf");
      applyStimulus(0, 0, 0, 0, 0, 1);
      checkOutput("snap ovf flush");
      applyStimulus(0, 1, 0, 0, 0, 0);
      checkOutput("snap ovf sticky");

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         applyStimulus($urandom_range(0, 1), $urandom_range(0, 1), $urandom,
                       ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
                       ($urandom_range(0, 15) == 0));
         checkOutput("random");
      end

      // Asynchronous reset in the middle of a cycle
      #2 rst = 1'b0;
      #1 modelReset();
      checkOutput("async reset");
      @(negedge clk) rst = 1'b1;
      applyStimulus(1, 0, 32'hBEEF, 0, 0, 0);
      checkOutput("post reset push");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

// File: doc/return_address_stack.md
# return_address_stack

Return address stack feeding fetch-stage target prediction for returns. Fetch pushes the fall-through PC when the branch predictor flags a fetched call and pops when it flags a return. The top entry is offered as the predicted return target. Speculative pointer state is checkpointed per in-flight predicted branch, so the stack can be rolled back on an early branch flush and released when the branch predictor reports `branch_retired`.

## Interface
Parameters:
- `RAS_DEPTH`, default 8: number of stack entries; power of two, ≥2.
- `SNAPSHOT_DEPTH`, default 8: number of checkpoint FIFO entries; power of two, ≥2.

Ports:
- `clk` input 1: single clock; all state on rising edge.
- `rst` input 1: reset, asynchronous assert, active-low.
- `push` input 1: fetched instruction is a call; `new_addr` is written as the new top.
- `pop` input 1: fetched instruction is a return; the top entry is discarded.
- `new_addr` input 32: return address to push.
- `addr` output 32: current top entry; `0` when `valid`=0.
- `valid` output 1: stack holds at least one entry.
- `branch_fetched` input 1: a predicted branch was fetched this cycle; take a checkpoint.
- `branch_retired` input 1: the oldest checkpointed branch resolved; release its checkpoint.
- `early_branch_flush` input 1: the oldest checkpointed branch mispredicted; roll back.
- `snapshot_overflow` output 1: sticky flag, set when a checkpoint is dropped.

## Operation
- **State:**
  - `read_index` [log2 RAS_DEPTH]: points at the top entry.
  - `count` [0..RAS_DEPTH], saturating.
  - LUTRAM stack, 32 bits × RAS_DEPTH, with no reset.
  - Checkpoint FIFO of {`read_index`, `count`}, with its own head/tail pointers and occupancy counter.
- **`addr`:** combinational read of `stack[read_index]`, gated to 0 when `count`=0.
- **`valid`:** equals `count`≠0.
- **push only:**
  - Write `stack[read_index+1] <= new_addr`; `read_index` increments modulo RAS_DEPTH.
  - `count` = min(`count`+1, RAS_DEPTH).
  - On overflow the oldest entry is silently overwritten.
- **pop only:**
  - If `count`>0: `read_index` decrements modulo RAS_DEPTH and `count` decrements.
  - If `count`=0: no change.
- **push and pop together:** write `stack[read_index] <= new_addr`; `read_index` and `count` unchanged. If `count`=0 this behaves as a push.
- **branch_fetched:**
  - Enqueue the post-update {`read_index`, `count`}, i.e. the state after this cycle's push/pop.
  - FIFO full and no retire in the same cycle: drop the oldest entry, enqueue the new one, set `snapshot_overflow`.
- **branch_retired:** dequeue the head. Ignored when the FIFO is empty.
- **Retire and fetch in the same cycle:** both take effect; occupancy is unchanged.
- **early_branch_flush:**
  - If the FIFO is non-empty: load `read_index`/`count` from the head and clear the FIFO.
  - If the FIFO is empty: pointer state is unchanged.
  - Flush has priority: same-cycle `push`, `pop`, `branch_fetched` and `branch_retired` are ignored entirely, including the stack write.
- **Stack contents:** never rolled back. Entries overwritten by speculative pushes stay corrupted; this is an accepted prediction-accuracy loss.
- **`snapshot_overflow`:** cleared only by reset.

## Timing
- **Reset values:**
  - `read_index`=0, `count`=0, FIFO empty.
  - `valid`=0, `addr`=0, `snapshot_overflow`=0.
- **Reset mid-operation:** asynchronous assertion clears all state immediately. Stack RAM contents are irrelevant because `count`=0.
- **Push latency:** a push in cycle N is visible on `addr`/`valid` in cycle N+1. There is no same-cycle bypass.
- **Pop latency:** a pop in cycle N exposes the next-older entry in cycle N+1.
- **Flush latency:** a flush in cycle N restores state visible in cycle N+1.
- **Handshakes:** none; all inputs are single-cycle qualifiers sampled every cycle and there is no backpressure.
- **Wrap:** `read_index` and the FIFO pointers wrap modulo their depths with no bubble.

## Configuration
- **`RAS_SNAPSHOT_EN` defined:** checkpoint FIFO and rollback are implemented as described.
- **`RAS_SNAPSHOT_EN` undefined:**
  - No FIFO is instantiated; `branch_fetched`, `branch_retired` and `early_branch_flush` are ignored.
  - The stack is non-recoverable; `snapshot_overflow` is tied 0.
  - Push/pop behaviour is identical.

## Test plan
- **Reset, push, pop:** reset, then push 0x100 and push 0x200 on consecutive cycles.
  - Next cycle: `addr`=0x200, `valid`=1.
  - Pop: `addr`=0x100.
  - Pop: `valid`=0, `addr`=0.
  - Further pop: state unchanged.
- **Overflow:** 9 pushes of 0x10..0x90 with RAS_DEPTH=8 → `addr`=0x90. Eight pops return 0x80..0x20, then `valid`=0 (0x10 overwritten, `count` saturated at 8).
- **Simultaneous push/pop:** with top 0x40, assert push+pop with `new_addr`=0x44 → `addr`=0x44 and depth unchanged; one pop gives `valid`=0.
- **Rollback:**
  - Push 0x100 together with `branch_fetched` (checkpoint `count`=1).
  - Push 0x200, then assert `early_branch_flush` together with push 0x300 → next cycle `addr`=0x100, `count`=1.
  - The 0x300 push has no effect; the FIFO is empty.
- **Retire ordering:** three `branch_fetched`, two `branch_retired`, then a flush → state is restored from the third checkpoint. A retire with an empty FIFO is a no-op.
- **Snapshot overflow:** with SNAPSHOT_DEPTH=8, nine `branch_fetched` with no retire → `snapshot_overflow`=1 and stays 1 until reset. A flush restores the second checkpoint.
